ps2_device_rxtx: RTL and testbench
==================================

// Module: ps2_device_rxtx
// PURPOSE
//  PS/2 device-side (keyboard/mouse emulator) link layer: generates ps2_clk, sends device->host
//  frames, receives host->device commands (request-to-send), returns the line-ack bit.
//  Drives open-drain PS/2 pins via low-only enables; sits opposite the host stack as a bench/FPGA peer.
// PARAMETERS
//  HALF_CYC     2000  clk cycles per ps2_clk half period (50 MHz / 12.5 kHz / 2)
//  RTS_MIN_CYC  5000  min clk cycles host must hold ps2_clk low to qualify an RTS (100 us @ 50 MHz)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active low
//  ps2_clk_i    in   1  ps2_clk pin level (async; 2-flop synced inside)
//  ps2_clk_oe   out  1  1 = drive ps2_clk low, 0 = release
//  ps2_data_i   in   1  ps2_data pin level (async; 2-flop synced inside)
//  ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release
//  tx_valid     in   1  byte to host available
//  tx_data      in   8  byte to host
//  tx_ready     out  1  accepts tx_data when tx_valid && tx_ready
//  tx_done      out  1  1-cycle pulse: frame fully sent (stop bit clocked)
//  tx_abort     out  1  1-cycle pulse: host inhibited mid-frame; byte dropped
//  rx_valid     out  1  1-cycle pulse: host command received
//  rx_data      out  8  received command, held until next rx_valid
//  rx_perr      out  1  qualifies rx_valid: odd-parity error or stop bit = 0
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, pins released. tx_ready rises once IDLE and synced clk/data high.
//  Bit timer: counts HALF_CYC; each bit = low phase (clk_oe=1) HALF_CYC, then high phase HALF_CYC.
//  States: IDLE, TX_BIT, RX_WAIT, RX_BIT, RX_ACK, INHIBIT.
//  IDLE: tx_ready=1 only while synced clk=1 and data=1.
//   - tx_valid&&tx_ready -> latch byte, compute odd parity, TX_BIT; start bit (data_oe=1) next cycle.
//   - synced clk low -> INHIBIT (tx_ready drops same cycle; RX path wins any same-cycle tx_valid).
//  TX_BIT: 11 bits: start 0, D0..D7 LSB first, odd parity, stop 1. data_oe = ~bit.
//   - data changes HALF_CYC/2 into the high phase; first clk low HALF_CYC/2 after start bit driven.
//   - at end of each high phase, synced clk_i=0 while clk_oe=0 => host inhibit: release both pins,
//     tx_abort pulse, -> INHIBIT. Checked through stop bit; after stop high phase -> tx_done, IDLE.
//  INHIBIT: count cycles with synced clk=0. On clk release: count>=RTS_MIN_CYC and data=0 -> RX_WAIT;
//   else -> IDLE. Count saturates at RTS_MIN_CYC.
//  RX_WAIT: wait HALF_CYC with pins released, then RX_BIT.
//  RX_BIT: device clocks 10 pulses; samples synced data_i at end of high phase of each:
//   D0..D7, parity, stop. Inhibit check as in TX (-> INHIBIT, no rx_valid).
//  RX_ACK: after stop sample, drive data_oe=1 for one full clock pulse (low+high), then release
//   both pins, pulse rx_valid with rx_data and rx_perr = (^{D,P}==0) | ~stop; -> IDLE.
//   Ack issued even on parity error.
//  Data never changes while clk_oe=1; clk_oe never asserted while synced clk_i already low in IDLE.
//  Reset mid-frame: pins released immediately (async), no done/abort/valid pulses emitted.
// TESTING
//  1 TX 0x1C via host bench model -> host captures 0x1C, parity bit 0, 11 clocks, tx_done once;
//    tx_ready low from accept until done.
//  2 Host RTS (clk low 120 us, data low, release clk) sending 0xED, parity 1 ->
//    rx_valid 1 cycle, rx_data=0xED, rx_perr=0; ack bit seen low on 11th clock.
//  3 Host sends 0x55 with parity 0 (wrong) -> rx_valid, rx_data=0x55, rx_perr=1, ack still driven.
//  4 Host pulls clk low during TX bit D3 of 0xAA -> tx_abort pulse; both oe=0 within 3 clk cycles;
//    no tx_done; subsequent RTS command 0xF4 received correctly.
//  5 tx_valid asserted same cycle synced clk falls (host RTS) -> no accept, command received, then
//    held tx_valid accepted after rx_valid; also clk low 40 us then released -> back to IDLE, no RX.
//  6 Assert rst_n=0 mid-TX bit 5 -> oe outputs 0 asynchronously, no pulses; after release,
//    tx_ready=1 and a new 0x1C frame sends cleanly.

Source files
------------

// File: rtl/ps2_device_rxtx.sv
// ps2_device_rxtx: device-side PS/2 link layer (keyboard/mouse emulator).
// Generates ps2_clk, sends device->host frames and receives host->device
// commands after a host request-to-send, returning the line-ack bit.
// Pins are open-drain: *_oe=1 pulls the line low, 0 releases it.
// Ports:
//   clk, rst_n               system clock, async active-low reset
//   ps2_clk_i / ps2_clk_oe   clock pin level in / low-drive enable out
//   ps2_data_i / ps2_data_oe data pin level in / low-drive enable out
//   tx_valid, tx_data, tx_ready   byte-to-host handshake
//   tx_done, tx_abort        1-cycle pulses: frame sent / host inhibited frame
//   rx_valid, rx_data, rx_perr    received command (pulse, held data, error)
module ps2_device_rxtx #(
  parameter int HALF_CYC    = 2000,
  parameter int RTS_MIN_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_oe,
  input  logic       ps2_data_i,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_perr
);
  localparam int TW = $clog2(HALF_CYC + 1);
  localparam int IW = $clog2(RTS_MIN_CYC + 1);
  localparam logic [TW-1:0] T_END = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0] T_MID = TW'(HALF_CYC / 2 - 1);
  localparam logic [IW-1:0] I_MIN = IW'(RTS_MIN_CYC);

  typedef enum logic [2:0] {IDLE, TX_BIT, RX_WAIT, RX_BIT, RX_ACK, INHIBIT} state_e;
  // SETUP is the half-period lead-in before the first clock pulse (TX start
  // bit, RX ack); LOW/HIGH are the two halves of each generated pulse.
  typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH} phase_e;

  logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  state_e state_q, state_d;
  phase_e ph_q, ph_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [3:0] cnt_q, cnt_d;
  logic [10:0] tx_sh_q, tx_sh_d;
  logic [9:0] rx_sh_q, rx_sh_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic tx_done_q, tx_done_d, tx_abort_q, tx_abort_d;
  logic rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d;
  logic [7:0] rx_data_q, rx_data_d;

  assign tx_ready    = (state_q == IDLE) && clk_sync_q && data_sync_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = tx_done_q;
  assign tx_abort    = tx_abort_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_perr     = rx_perr_q;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    tmr_d      = tmr_q + TW'(1);
    inh_d      = inh_q;
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    tx_done_d  = 1'b0;
    tx_abort_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    case (state_q)
      IDLE: begin
        tmr_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        // Host holding clk low always wins over a pending transmit.
        if (!clk_sync_q) begin
          state_d = INHIBIT;
          inh_d   = '0;
        end else if (tx_valid && tx_ready) begin
          state_d   = TX_BIT;
          ph_d      = PH_SETUP;
          cnt_d     = '0;
          tx_sh_d   = {1'b1, ~^tx_data, tx_data, 1'b0};
          data_oe_d = 1'b1;
        end
      end
      TX_BIT, RX_BIT, RX_ACK: begin
        case (ph_q)
          PH_SETUP: if (tmr_q == T_MID) begin
            tmr_d = '0;
            if (state_q == TX_BIT && !clk_sync_q) begin
              state_d    = INHIBIT;
              inh_d      = '0;
              data_oe_d  = 1'b0;
              tx_abort_d = 1'b1;
            end else begin
              ph_d     = PH_LOW;
              clk_oe_d = 1'b1;
            end
          end
          PH_LOW: if (tmr_q == T_END) begin
            tmr_d    = '0;
            ph_d     = PH_HIGH;
            clk_oe_d = 1'b0;
          end
          default: begin
            // Next TX bit goes out mid-way through the high phase so the
            // data line is never touched while the clock is driven low.
            if (state_q == TX_BIT && tmr_q == T_MID && cnt_q != 4'd10) begin
              tx_sh_d   = {1'b1, tx_sh_q[10:1]};
              data_oe_d = ~tx_sh_q[1];
            end
            if (tmr_q == T_END) begin
              tmr_d = '0;
              if (state_q == RX_ACK) begin
                state_d    = IDLE;
                data_oe_d  = 1'b0;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_sh_q[7:0];
                rx_perr_d  = ~(^rx_sh_q[8:0]) | ~rx_sh_q[9];
              end else if (!clk_sync_q) begin
                // Clock released by us but seen low: host inhibit.
                state_d    = INHIBIT;
                inh_d      = '0;
                data_oe_d  = 1'b0;
                tx_abort_d = (state_q == TX_BIT);
              end else if (state_q == TX_BIT && cnt_q == 4'd10) begin
                state_d   = IDLE;
                tx_done_d = 1'b1;
                data_oe_d = 1'b0;
              end else if (state_q == RX_BIT && cnt_q == 4'd9) begin
                rx_sh_d   = {data_sync_q, rx_sh_q[9:1]};
                state_d   = RX_ACK;
                ph_d      = PH_SETUP;
                data_oe_d = 1'b1;
              end else begin
                if (state_q == RX_BIT) rx_sh_d = {data_sync_q, rx_sh_q[9:1]};
                cnt_d    = cnt_q + 4'd1;
                ph_d     = PH_LOW;
                clk_oe_d = 1'b1;
              end
            end
          end
        endcase
      end
      RX_WAIT: if (tmr_q == T_END) begin
        tmr_d    = '0;
        state_d  = RX_BIT;
        ph_d     = PH_LOW;
        cnt_d    = '0;
        clk_oe_d = 1'b1;
      end
      default: begin // INHIBIT
        tmr_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (!clk_sync_q) begin
          if (inh_q != I_MIN) inh_d = inh_q + IW'(1);
        end else if (inh_q == I_MIN && !data_sync_q) begin
          state_d = RX_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {clk_sync_q, clk_meta_q}   <= 2'b00;
      {data_sync_q, data_meta_q} <= 2'b00;
      state_q    <= IDLE;
      ph_q       <= PH_SETUP;
      tmr_q      <= '0;
      inh_q      <= '0;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      {clk_sync_q, clk_meta_q}   <= {clk_meta_q, ps2_clk_i};
      {data_sync_q, data_meta_q} <= {data_meta_q, ps2_data_i};
      state_q    <= state_d;
      ph_q       <= ph_d;
      tmr_q      <= tmr_d;
      inh_q      <= inh_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_abort_q <= tx_abort_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
    end
  end
endmodule

// File: tb/tb_ps2_device_rxtx.sv
// Bench for ps2_device_rxtx: a host-side line model plus a frame-level
// reference (wire bit order, odd parity, error rules) checks TX frames,
// host commands, inhibit/abort handling and reset behaviour.
module tb_ps2_device_rxtx;
  localparam int H   = 8;
  localparam int RTS = 20;

  logic clk = 1'b0, rst_n = 1'b0;
  logic host_clk_low = 1'b0, host_data_low = 1'b0;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_done, tx_abort, rx_valid, rx_perr;
  logic [7:0] rx_data;

  assign ps2_clk_i  = ~(ps2_clk_oe  | host_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | host_data_low);
  always #5 clk = ~clk;

  ps2_device_rxtx #(.HALF_CYC(H), .RTS_MIN_CYC(RTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk_i(ps2_clk_i), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_i(ps2_data_i), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_abort(tx_abort),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr)
  );

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, abort_cnt = 0, rxv_cnt = 0, viol_cnt = 0, acc_cnt = 0, acc_rxv = 0;
  logic rxv_perr = 1'b0;
  logic [1:0] fall_q[$];   // {data_oe, data pin} at each ps2_clk falling edge
  logic clk_pin_prev = 1'b1, coe_prev = 1'b0, doe_prev = 1'b0;

  // Line/event monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (clk_pin_prev && !ps2_clk_i) fall_q.push_back({ps2_data_oe, ps2_data_i});
    if (coe_prev && ps2_clk_oe && (doe_prev != ps2_data_oe)) viol_cnt <= viol_cnt + 1;
    if (tx_done)  done_cnt  <= done_cnt + 1;
    if (tx_abort) abort_cnt <= abort_cnt + 1;
    if (rx_valid) begin rxv_cnt <= rxv_cnt + 1; rxv_perr <= rx_perr; end
    if (tx_valid && tx_ready) begin acc_cnt <= acc_cnt + 1; acc_rxv <= rxv_cnt; end
    clk_pin_prev <= ps2_clk_i;
    coe_prev     <= ps2_clk_oe;
    doe_prev     <= ps2_data_oe;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Odd parity: parity bit is 1 when the data byte has an even number of ones.
  function automatic logic odd_par(input logic [7:0] b);
    return logic'(($countones(b) % 2) == 0);
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!tx_ready && t < 300) begin step(); t++; end
    chk({tag, "_ready"}, 32'(tx_ready), 1);
  endtask

  // Device -> host frame; exp_par is the parity bit expected on the wire.
  task automatic dev_tx(input logic [7:0] b, input logic exp_par, input string tag);
    int t = 0, bad_rdy = 0, d0, a0;
    logic [10:0] got, exp;
    wait_ready(tag);
    fall_q.delete();
    d0 = done_cnt; a0 = abort_cnt;
    tx_data = b; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk({tag, "_busy"}, 32'(tx_ready), 0);
    while (done_cnt == d0 && abort_cnt == a0 && t < 24 * H + 100) begin
      if (tx_ready && !tx_done) bad_rdy++;
      step(); t++;
    end
    got = '0;
    for (int i = 0; i < 11; i++) if (i < fall_q.size()) got[i] = fall_q[i][0];
    exp = {1'b1, exp_par, b, 1'b0};
    chk({tag, "_done"}, 32'(done_cnt - d0), 1);
    chk({tag, "_noabort"}, 32'(abort_cnt - a0), 0);
    chk({tag, "_rdy_low"}, 32'(bad_rdy), 0);
    chk({tag, "_nclk"}, 32'(fall_q.size()), 11);
    chk({tag, "_bits"}, 32'(got), 32'(exp));
  endtask

  // Host request-to-send followed by a 10-bit command; checks the result.
  task automatic host_cmd(input logic [7:0] b, input logic par, input logic stop,
                          input logic exp_perr, input string tag);
    int t, r0;
    logic [9:0] bits;
    logic ack;
    bits = {stop, par, b};
    r0 = rxv_cnt;
    host_clk_low = 1'b1;
    repeat (RTS + 10) step();
    host_data_low = 1'b1;
    repeat (3) step();
    fall_q.delete();
    host_clk_low = 1'b0;
    for (int k = 0; k < 11; k++) begin
      t = 0;
      while (fall_q.size() <= k && t < 6 * H + 20) begin step(); t++; end
      if (fall_q.size() <= k) break;
      host_data_low = (k < 10) ? ~bits[k] : 1'b0;
    end
    host_data_low = 1'b0;
    t = 0;
    while (rxv_cnt == r0 && t < 4 * H + 20) begin step(); t++; end
    ack = (fall_q.size() > 10) ? fall_q[10][1] : 1'b0;
    chk({tag, "_nclk"}, 32'(fall_q.size()), 11);
    chk({tag, "_rxv"}, 32'(rxv_cnt - r0), 1);
    chk({tag, "_data"}, 32'(rx_data), 32'(b));
    chk({tag, "_perr"}, 32'(rxv_perr), 32'(exp_perr));
    chk({tag, "_ack"}, 32'(ack), 1);
  endtask

  typedef struct {
    bit         is_tx;
    logic [7:0] d;
    logic       par;      // RX: parity bit the host sends
    logic       stop;     // RX: stop bit the host sends
    logic       exp_par;  // TX: parity bit expected on the wire
    logic       exp_perr; // RX: expected rx_perr
  } vec_t;

  initial begin
    vec_t tbl[8];
    int t, d0, a0, r0, c0;
    logic [7:0] b;
    logic p, s;

    tbl[0] = '{1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'hED, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) step();
    chk("reset_outs", 32'({ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_abort,
                           rx_valid, rx_perr, rx_data}), 0);
    rst_n = 1'b1;
    wait_ready("post_reset");

    // Table vectors
    foreach (tbl[i]) begin
      if (tbl[i].is_tx) dev_tx(tbl[i].d, tbl[i].exp_par, $sformatf("vec%0d_tx", i));
      else host_cmd(tbl[i].d, tbl[i].par, tbl[i].stop, tbl[i].exp_perr,
                    $sformatf("vec%0d_rx", i));
      repeat (3) step();
    end

    // Host inhibit during TX bit D3, then a command
    wait_ready("abort");
    d0 = done_cnt; a0 = abort_cnt;
    fall_q.delete();
    tx_data = 8'hAA; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    t = 0;
    while (fall_q.size() < 5 && t < 20 * H) begin step(); t++; end
    t = 0;
    while (!ps2_clk_i && t < 4 * H) begin step(); t++; end
    host_clk_low = 1'b1;
    t = 0;
    while (abort_cnt == a0 && t < 4 * H) begin step(); t++; end
    chk("abort_pulse", 32'(abort_cnt - a0), 1);
    chk("abort_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    host_cmd(8'hF4, odd_par(8'hF4), 1'b1, 1'b0, "abort_rx");
    chk("abort_nodone", 32'(done_cnt - d0), 0);
    chk("abort_single", 32'(abort_cnt - a0), 1);

    // tx_valid raised the cycle synced clk goes low: RX wins, TX follows
    wait_ready("rts_race");
    c0 = acc_cnt; r0 = rxv_cnt; d0 = done_cnt;
    host_clk_low = 1'b1;
    step(); step();
    tx_data = 8'h1C; tx_valid = 1'b1;
    chk("race_ready_low", 32'(tx_ready), 0);
    host_cmd(8'hF2, odd_par(8'hF2), 1'b1, 1'b0, "race_rx");
    t = 0;
    while (acc_cnt == c0 && t < 50) begin step(); t++; end
    tx_valid = 1'b0;
    chk("race_accept", 32'(acc_cnt - c0), 1);
    chk("race_accept_after_rx", 32'(acc_rxv - r0), 1);
    t = 0;
    while (done_cnt == d0 && t < 24 * H + 100) begin step(); t++; end
    chk("race_tx_done", 32'(done_cnt - d0), 1);

    // Clock held low with data high (short and long): back to IDLE, no RX
    foreach (tbl[i]) if (i < 2) begin
      r0 = rxv_cnt;
      host_clk_low = 1'b1;
      repeat ((i == 0) ? RTS / 3 : RTS + 10) step();
      host_clk_low = 1'b0;
      repeat (5) step();
      fall_q.delete();
      repeat (3 * H) step();
      chk($sformatf("inh%0d_noclk", i), 32'(fall_q.size()), 0);
      chk($sformatf("inh%0d_norx", i), 32'(rxv_cnt - r0), 0);
      chk($sformatf("inh%0d_ready", i), 32'(tx_ready), 1);
    end

    // Randomized traffic against the frame-level model
    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        dev_tx(b, odd_par(b), $sformatf("rnd%0d_tx", n));
      end else begin
        p = odd_par(b) ^ ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 4) != 0);
        host_cmd(b, p, s, (p != odd_par(b)) || !s, $sformatf("rnd%0d_rx", n));
      end
      repeat ($urandom_range(1, 6)) step();
    end

    // Reset mid-TX (bit D5): pins drop asynchronously, no pulses
    wait_ready("rst_mid");
    d0 = done_cnt; a0 = abort_cnt; r0 = rxv_cnt;
    fall_q.delete();
    tx_data = 8'h1C; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    t = 0;
    while (fall_q.size() < 7 && t < 20 * H) begin step(); t++; end
    step(); step();
    #2 rst_n = 1'b0;
    #1 chk("rst_oe_async", 32'({ps2_clk_oe, ps2_data_oe}), 0);
    repeat (3) step();
    chk("rst_no_pulses", 32'((done_cnt - d0) + (abort_cnt - a0) + (rxv_cnt - r0)), 0);
    chk("rst_outs", 32'({tx_ready, rx_valid, rx_perr, rx_data}), 0);
    rst_n = 1'b1;
    dev_tx(8'h1C, 1'b0, "rst_after_tx");

    chk("data_stable_under_clk", 32'(viol_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
